// File: rtl/sound_arbiter_pkg.sv
// sound_pkg: shared constants for the sound arbiter.
// Holds the effect/event codes, the per-effect step counts, the note
// table (frequency in Hz, duration in ms for every step) and a helper
// that turns a note frequency into a tone half-period in clock cycles.
package sound_pkg;

  // Event code doubles as priority: a larger code preempts a smaller one.
  typedef enum logic [1:0] {
    EVT_NONE  = 2'd0,
    EVT_BEEP  = 2'd1,
    EVT_LAP   = 2'd2,
    EVT_CRASH = 2'd3
  } evt_t;

  localparam int BEEP_STEPS  = 1;
  localparam int LAP_STEPS   = 3;
  localparam int CRASH_STEPS = 3;

  // Note table. A frequency of 0 Hz marks a rest step.
  localparam int BEEP0_HZ  = 1000;
  localparam int BEEP0_MS  = 100;
  localparam int LAP0_HZ   = 800;
  localparam int LAP0_MS   = 80;
  localparam int LAP1_HZ   = 1000;
  localparam int LAP1_MS   = 80;
  localparam int LAP2_HZ   = 1250;
  localparam int LAP2_MS   = 80;
  localparam int CRASH0_HZ = 400;
  localparam int CRASH0_MS = 150;
  localparam int CRASH1_HZ = 0;
  localparam int CRASH1_MS = 50;
  localparam int CRASH2_HZ = 400;
  localparam int CRASH2_MS = 150;

  // Half-period in cycles, truncated, never below 1. A rest returns 0,
  // which the arbiter uses to keep the tone divider disabled.
  function automatic int half_period(input int clk_hz, input int f);
    int h;
    if (f == 0) return 0;
    h = clk_hz / (2 * f);
    if (h < 1) h = 1;
    return h;
  endfunction

  function automatic int steps_of(input logic [1:0] evt);
    case (evt)
      2'd1:    return BEEP_STEPS;
      2'd2:    return LAP_STEPS;
      2'd3:    return CRASH_STEPS;
      default: return 1;
    endcase
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sound_arbiter_if.sv
// sound_arbiter_if: bundles the control, request and output signals of
// the sound arbiter.
//   master : game/engine side; drives mute, engine_en, engine_piezo and
//            the evt_* request pulses; observes piezo, busy, active_evt
//   slave  : the arbiter itself
interface sound_arbiter_if;
  logic       mute;
  logic       engine_en;
  logic       engine_piezo;
  logic       evt_beep;
  logic       evt_lap;
  logic       evt_crash;
  logic       piezo;
  logic       busy;
  logic [1:0] active_evt;

  modport master (
    output mute, engine_en, engine_piezo, evt_beep, evt_lap, evt_crash,
    input  piezo, busy, active_evt
  );

  modport slave (
    input  mute, engine_en, engine_piezo, evt_beep, evt_lap, evt_crash,
    output piezo, busy, active_evt
  );
endinterface

// File: rtl/sound_arbiter_tone_divider.sv
// tone_divider: square-wave generator for one effect step.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   restart  : clears counter and tone at the next edge (step start)
//   half     : half-period in cycles (>= 1 while enabled)
//   enable   : run the divider; low holds counter and tone at 0
//   tone     : square wave output
module tone_divider #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         restart,
  input  logic [N-1:0] half,
  input  logic         enable,
  output logic         tone
);

  logic [N-1:0] cnt;

  // Restart wins over counting so every step begins from a clean phase:
  // the first toggle lands exactly half cycles after the step start.
  always_ff @(posedge clk) begin
    if (rst || restart || !enable) begin
      cnt  <= '0;
      tone <= 1'b0;
    end else if (cnt == half - 1'b1) begin
      cnt  <= '0;
      tone <= ~tone;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sound_arbiter.sv
// sound_arbiter: owns the piezo pin and shares it between the engine
// tone and three one-shot effects (beep, lap, crash) played from the
// note table in sound_pkg, with higher codes preempting lower ones.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : sound_arbiter_if.slave (mute, engine_en, engine_piezo,
//              evt_beep/lap/crash in; piezo, busy, active_evt out)
module sound_arbiter
  import sound_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 1_000_000
) (
  input logic            clk,
  input logic            rst,
  sound_arbiter_if.slave bus
);

  localparam int MS_CYCLES = CLK_FREQ_HZ / 1000;

  localparam int H_B0 = half_period(CLK_FREQ_HZ, BEEP0_HZ);
  localparam int H_L0 = half_period(CLK_FREQ_HZ, LAP0_HZ);
  localparam int H_L1 = half_period(CLK_FREQ_HZ, LAP1_HZ);
  localparam int H_L2 = half_period(CLK_FREQ_HZ, LAP2_HZ);
  localparam int H_C0 = half_period(CLK_FREQ_HZ, CRASH0_HZ);
  localparam int H_C1 = half_period(CLK_FREQ_HZ, CRASH1_HZ);
  localparam int H_C2 = half_period(CLK_FREQ_HZ, CRASH2_HZ);

  localparam int L_B0 = BEEP0_MS * MS_CYCLES;
  localparam int L_L0 = LAP0_MS * MS_CYCLES;
  localparam int L_L1 = LAP1_MS * MS_CYCLES;
  localparam int L_L2 = LAP2_MS * MS_CYCLES;
  localparam int L_C0 = CRASH0_MS * MS_CYCLES;
  localparam int L_C1 = CRASH1_MS * MS_CYCLES;
  localparam int L_C2 = CRASH2_MS * MS_CYCLES;

  localparam int MAX_HALF = max2(max2(max2(H_B0, H_L0), max2(H_L1, H_L2)),
                                 max2(max2(H_C0, H_C1), H_C2));
  localparam int MAX_LEN  = max2(max2(max2(L_B0, L_L0), max2(L_L1, L_L2)),
                                 max2(max2(L_C0, L_C1), L_C2));
  localparam int HALF_W   = $clog2(MAX_HALF + 1);
  localparam int LEN_W    = $clog2(MAX_LEN);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_PLAY = 1'b1;

  logic [0:0]       state, state_n;
  logic [1:0]       active_evt, active_n;
  logic [1:0]       step, step_n;
  logic [LEN_W-1:0] step_cnt, cnt_n;
  logic [2:0]       pending, pending_n;
  logic [2:0]       play_mask;
  logic [1:0]       top_evt;
  logic [HALF_W-1:0] cur_half;
  logic [LEN_W-1:0] cur_last;
  logic             last_step;
  logic             restart;
  logic             tone;
  logic             piezo_q;

  // Look up the note of the current step; unused codes fall to a rest.
  always_comb begin
    cur_half = '0;
    cur_last = '0;
    case (active_evt)
      EVT_BEEP: begin
        cur_half = HALF_W'(H_B0);
        cur_last = LEN_W'(L_B0 - 1);
      end
      EVT_LAP: begin
        case (step)
          2'd0:    begin cur_half = HALF_W'(H_L0); cur_last = LEN_W'(L_L0 - 1); end
          2'd1:    begin cur_half = HALF_W'(H_L1); cur_last = LEN_W'(L_L1 - 1); end
          default: begin cur_half = HALF_W'(H_L2); cur_last = LEN_W'(L_L2 - 1); end
        endcase
      end
      EVT_CRASH: begin
        case (step)
          2'd0:    begin cur_half = HALF_W'(H_C0); cur_last = LEN_W'(L_C0 - 1); end
          2'd1:    begin cur_half = HALF_W'(H_C1); cur_last = LEN_W'(L_C1 - 1); end
          default: begin cur_half = HALF_W'(H_C2); cur_last = LEN_W'(L_C2 - 1); end
        endcase
      end
      default: ;
    endcase
  end

  assign last_step = (step == 2'(steps_of(active_evt) - 1));

  // Highest pending request; pending bit i belongs to event code i+1.
  always_comb begin
    if (pending[2])      top_evt = EVT_CRASH;
    else if (pending[1]) top_evt = EVT_LAP;
    else if (pending[0]) top_evt = EVT_BEEP;
    else                 top_evt = EVT_NONE;
  end

  // A repeat request for the effect already playing is swallowed here
  // so it neither restarts nor queues a replay.
  always_comb begin
    play_mask = '0;
    if (state == ST_PLAY && active_evt != EVT_NONE)
      play_mask[active_evt - 2'd1] = 1'b1;
  end

  // Next-state logic: mute overrides everything, otherwise launch or
  // preempt with the highest pending effect, else walk through steps.
  always_comb begin
    state_n   = state;
    active_n  = active_evt;
    step_n    = step;
    cnt_n     = step_cnt;
    restart   = 1'b0;
    pending_n = pending | ({bus.evt_crash, bus.evt_lap, bus.evt_beep} & ~play_mask);

    if (bus.mute) begin
      pending_n = '0;
      state_n   = ST_IDLE;
      active_n  = EVT_NONE;
      step_n    = '0;
      cnt_n     = '0;
    end else if ((state == ST_IDLE && top_evt != EVT_NONE) ||
                 (state == ST_PLAY && top_evt > active_evt)) begin
      state_n   = ST_PLAY;
      active_n  = top_evt;
      step_n    = '0;
      cnt_n     = '0;
      restart   = 1'b1;
      pending_n[top_evt - 2'd1] = 1'b0;
    end else if (state == ST_PLAY) begin
      if (step_cnt == cur_last) begin
        cnt_n   = '0;
        restart = 1'b1;
        if (last_step) begin
          state_n  = ST_IDLE;
          active_n = EVT_NONE;
          step_n   = '0;
        end else begin
          step_n = step + 2'd1;
        end
      end else begin
        cnt_n = step_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      active_evt <= EVT_NONE;
      step       <= '0;
      step_cnt   <= '0;
      pending    <= '0;
    end else begin
      state      <= state_n;
      active_evt <= active_n;
      step       <= step_n;
      step_cnt   <= cnt_n;
      pending    <= pending_n;
    end
  end

  tone_divider #(.N(HALF_W)) u_tone (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .half    (cur_half),
    .enable  (state == ST_PLAY && cur_half != '0),
    .tone    (tone)
  );

  // Registered output mux so the pin never glitches between sources.
  always_ff @(posedge clk) begin
    if (rst || bus.mute)       piezo_q <= 1'b0;
    else if (state == ST_PLAY) piezo_q <= tone;
    else                       piezo_q <= bus.engine_piezo & bus.engine_en;
  end

  assign bus.piezo      = piezo_q;
  assign bus.busy       = (state == ST_PLAY);
  assign bus.active_evt = active_evt;

endmodule

// File: tb/tb_sound_arbiter.sv
// tb_sound_arbiter: directed bench for sound_arbiter at 10 kHz
// (1 ms = 10 cycles). Traces of piezo/busy/active_evt are captured per
// cycle and compared against hand-computed note timings.
module tb_sound_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   check_count = 0;
  int   fail_count  = 0;
  int   r;
  int   n;

  logic       tr_p [0:3999];
  logic       tr_b [0:3999];
  logic [1:0] tr_a [0:3999];

  sound_arbiter_if bus ();

  sound_arbiter #(.CLK_FREQ_HZ(10_000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input int got, input int exp);
    check_count++;
    if (got !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // One-cycle request pulse(s), sampled by the next rising edge.
  task automatic applyStimulus(input logic b, input logic l, input logic c);
    bus.evt_beep  = b;
    bus.evt_lap   = l;
    bus.evt_crash = c;
    tick();
    bus.evt_beep  = 1'b0;
    bus.evt_lap   = 1'b0;
    bus.evt_crash = 1'b0;
  endtask

  // Index i holds the outputs after the (i+1)-th edge following a pulse,
  // so index 0 is the cycle right after the effect launches.
  task automatic record_trace(input int len);
    for (int i = 0; i < len; i++) begin
      tick();
      tr_p[i] = bus.piezo;
      tr_b[i] = bus.busy;
      tr_a[i] = bus.active_evt;
    end
  endtask

  function automatic int first_rise(input int from, input int to);
    for (int j = from + 1; j <= to; j++)
      if (!tr_p[j-1] && tr_p[j]) return j;
    return -1;
  endfunction

  function automatic int high_run(input int at);
    int cnt = 0;
    if (at < 0) return -1;
    for (int j = at; j < 4000 && tr_p[j]; j++) cnt++;
    return cnt;
  endfunction

  function automatic int ones_p(input int from, input int to);
    int cnt = 0;
    for (int j = from; j <= to; j++) cnt += int'(tr_p[j]);
    return cnt;
  endfunction

  function automatic int ones_b(input int from, input int to);
    int cnt = 0;
    for (int j = from; j <= to; j++) cnt += int'(tr_b[j]);
    return cnt;
  endfunction

  initial begin
    rst              = 1'b1;
    bus.mute         = 1'b0;
    bus.engine_en    = 1'b1;
    bus.engine_piezo = 1'b1;
    bus.evt_beep     = 1'b0;
    bus.evt_lap      = 1'b0;
    bus.evt_crash    = 1'b0;
    tick();
    tick();
    checkOutput("reset_piezo", bus.piezo, 0);
    checkOutput("reset_busy", bus.busy, 0);
    checkOutput("reset_active", bus.active_evt, 0);
    rst = 1'b0;

    // Engine passthrough, one cycle late
    begin
      logic [4:0] pat;
      pat = 5'b01101;
      for (int i = 0; i < 5; i++) begin
        bus.engine_piezo = pat[i];
        tick();
        checkOutput("engine_pass", bus.piezo, int'(pat[i]));
      end
    end
    bus.engine_en = 1'b0;
    bus.engine_piezo = 1'b1;
    tick();
    checkOutput("engine_disabled", bus.piezo, 0);
    checkOutput("idle_busy", bus.busy, 0);
    bus.engine_en = 1'b1;
    bus.engine_piezo = 1'b0;
    tick();

    // BEEP
    applyStimulus(1, 0, 0);
    checkOutput("beep_latency_busy0", bus.busy, 0);
    record_trace(1100);
    checkOutput("beep_busy_first", tr_b[0], 1);
    checkOutput("beep_active", tr_a[0], 1);
    r = first_rise(0, 200);
    checkOutput("beep_first_rise", r, 6);
    checkOutput("beep_half", high_run(r), 5);
    checkOutput("beep_busy_len", ones_b(0, 1099), 1000);
    checkOutput("beep_end_active", tr_a[1000], 0);
    bus.engine_piezo = 1'b1;
    tick();
    checkOutput("beep_pass_resume", bus.piezo, 1);
    bus.engine_piezo = 1'b0;
    tick();

    // Repeat BEEP while BEEP plays is dropped
    applyStimulus(1, 0, 0);
    repeat (500) tick();
    applyStimulus(1, 0, 0);
    n = 0;
    while (bus.busy && n < 3000) begin
      tick();
      n++;
    end
    checkOutput("beep_no_restart", n, 500);
    repeat (3) tick();
    checkOutput("beep_no_replay", bus.busy, 0);

    // LAP
    applyStimulus(0, 1, 0);
    record_trace(2500);
    checkOutput("lap_active", tr_a[0], 2);
    r = first_rise(0, 100);
    checkOutput("lap_s0_rise", r, 7);
    checkOutput("lap_s0_half", high_run(r), 6);
    r = first_rise(800, 900);
    checkOutput("lap_s1_rise", r, 806);
    checkOutput("lap_s1_half", high_run(r), 5);
    r = first_rise(1600, 1700);
    checkOutput("lap_s2_rise", r, 1605);
    checkOutput("lap_s2_half", high_run(r), 4);
    checkOutput("lap_busy_len", ones_b(0, 2499), 2400);

    // CRASH
    applyStimulus(0, 0, 1);
    record_trace(3600);
    checkOutput("crash_active", tr_a[0], 3);
    r = first_rise(0, 100);
    checkOutput("crash_s0_rise", r, 13);
    checkOutput("crash_s0_half", high_run(r), 12);
    checkOutput("crash_rest_silent", ones_p(1501, 2000), 0);
    r = first_rise(2000, 2100);
    checkOutput("crash_s2_rise", r, 2013);
    checkOutput("crash_s2_half", high_run(r), 12);
    checkOutput("crash_busy_len", ones_b(0, 3599), 3500);

    // CRASH preempts LAP; LAP is not resumed
    applyStimulus(0, 1, 0);
    repeat (300) tick();
    checkOutput("preempt_before", bus.active_evt, 2);
    applyStimulus(0, 0, 1);
    checkOutput("preempt_pending_only", bus.active_evt, 2);
    record_trace(3600);
    checkOutput("preempt_active", tr_a[0], 3);
    checkOutput("preempt_crash_rise", first_rise(0, 100), 13);
    checkOutput("preempt_busy_len", ones_b(0, 3599), 3500);
    checkOutput("preempt_no_resume", tr_b[3550], 0);

    // Simultaneous BEEP+LAP: LAP first, BEEP one cycle after LAP ends
    applyStimulus(1, 1, 0);
    record_trace(3500);
    checkOutput("dual_first", tr_a[0], 2);
    checkOutput("dual_gap", tr_a[2400], 0);
    checkOutput("dual_second", tr_a[2401], 1);
    checkOutput("dual_busy_len", ones_b(0, 3499), 3400);

    // Mute aborts CRASH and drops requests
    applyStimulus(0, 0, 1);
    repeat (100) tick();
    bus.mute = 1'b1;
    tick();
    checkOutput("mute_busy", bus.busy, 0);
    checkOutput("mute_piezo", bus.piezo, 0);
    checkOutput("mute_active", bus.active_evt, 0);
    applyStimulus(1, 0, 0);
    bus.engine_piezo = 1'b1;
    tick();
    checkOutput("mute_idle_piezo", bus.piezo, 0);
    bus.mute = 1'b0;
    bus.engine_piezo = 1'b0;
    repeat (3) tick();
    checkOutput("mute_dropped_req", bus.busy, 0);

    // Reset mid-effect with a request pending
    applyStimulus(0, 1, 0);
    repeat (50) tick();
    checkOutput("pre_reset_busy", bus.busy, 1);
    applyStimulus(1, 0, 0);
    rst = 1'b1;
    tick();
    checkOutput("rst_busy", bus.busy, 0);
    checkOutput("rst_active", bus.active_evt, 0);
    checkOutput("rst_piezo", bus.piezo, 0);
    rst = 1'b0;
    repeat (3) tick();
    checkOutput("rst_pending_cleared", bus.busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
    $finish;
  end

endmodule
